// File: rtl/issue_pkg.sv
// Shared field layout and wakeup helpers for the issue queue.
// Optional same-cycle bypass is enabled by defining ISSUE_BYPASS_EN.
package issue_pkg;

    localparam int INST_WIDTH = 47;
    localparam int NUM_SRC    = 4;
    localparam int TAG_W      = 5;
    localparam int TAG_COUNT  = 10;
    localparam int RDY_LSB    = 9;
    localparam int TAG_LSB    = 13;

    typedef logic [INST_WIDTH-1:0] instr_t;
    typedef logic [TAG_COUNT-1:0]  done_t;

    function automatic logic [TAG_W-1:0] src_tag(instr_t instr, int i);
        return instr[TAG_LSB+TAG_W*i +: TAG_W];
    endfunction

    function automatic logic src_rdy(instr_t instr, int i);
        return instr[RDY_LSB+i];
    endfunction

    // Tags at or above TAG_COUNT never match a done flag.
    function automatic instr_t wake(instr_t instr, done_t done_flags);
        instr_t           r;
        logic [TAG_W-1:0] t;
        logic             hit;
        r = instr;
        for (int s = 0; s < NUM_SRC; s++) begin
            t   = src_tag(instr, s);
            hit = 1'b0;
            for (int k = 0; k < TAG_COUNT; k++) begin
                if (t == TAG_W'(k) && done_flags[k]) hit = 1'b1;
            end
            r[RDY_LSB+s] = src_rdy(instr, s) | hit;
        end
        return r;
    endfunction

endpackage

// File: rtl/issue_wakeup.sv
// Combinational wakeup of one instruction against the completion broadcast.
// Used per queue entry and on the incoming instruction.
module issue_wakeup
    import issue_pkg::*;
(
    input  logic [INST_WIDTH-1:0] instr_i,
    input  logic [TAG_COUNT-1:0]  done_flags,
    output logic [INST_WIDTH-1:0] instr_o,
    output logic                  all_ready
);

    assign instr_o   = wake(instr_i, done_flags);
    assign all_ready = &instr_o[RDY_LSB +: NUM_SRC];

endmodule

// File: rtl/issue_select_queue.sv
// Age-ordered, compacting issue queue selecting the oldest ready entry.
// Define ISSUE_BYPASS_EN to let a ready instr_in issue in its arrival cycle.
module issue_select_queue
    import issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TAG_COUNT-1:0]       done_flags,
    input  logic [INST_WIDTH-1:0]      instr_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [INST_WIDTH-1:0]      instr_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(DEPTH);

`ifdef ISSUE_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    instr_t            data_q [DEPTH];
    instr_t            data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    instr_t            woken [DEPTH];
    logic [DEPTH-1:0]  all_rdy;
    logic [DEPTH-1:0]  elig;
    instr_t            in_woken;
    logic              in_all_rdy;

    logic              any_elig;
    logic [SW-1:0]     sel;
    logic              byp;
    logic              issue;
    logic              enq;
    logic [CW-1:0]     wr;

    instr_t            wk_x [DEPTH+1];
    logic [DEPTH:0]    vx;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wk
        issue_wakeup u_wk (
            .instr_i    (data_q[g]),
            .done_flags (done_flags),
            .instr_o    (woken[g]),
            .all_ready  (all_rdy[g])
        );
    end

    issue_wakeup u_in_wk (
        .instr_i    (instr_in),
        .done_flags (done_flags),
        .instr_o    (in_woken),
        .all_ready  (in_all_rdy)
    );

    assign elig = valid_q & all_rdy;

    always_comb begin
        any_elig = 1'b0;
        sel      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!any_elig && elig[i]) begin
                any_elig = 1'b1;
                sel      = SW'(i);
            end
        end
    end

    assign in_ready  = !rst && (count_q < CW'(DEPTH));
    assign byp       = BYP_EN && !any_elig && in_valid
                       && in_ready && in_all_rdy;
    assign out_valid = !rst && (any_elig || byp);
    assign instr_out = byp ? in_woken : woken[sel];
    assign count     = count_q;

    // A bypassed instruction consumed this cycle is never written.
    assign issue = !rst && any_elig && out_ready;
    assign enq   = in_valid && in_ready && !(byp && out_ready);
    assign wr    = issue ? count_q - CW'(1) : count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk_x[i] = woken[i];
            vx[i]   = valid_q[i];
        end
        wk_x[DEPTH] = '0;
        vx[DEPTH]   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && SW'(i) >= sel) begin
                data_d[i]  = wk_x[i+1];
                valid_d[i] = vx[i+1];
            end else begin
                data_d[i]  = wk_x[i];
                valid_d[i] = vx[i];
            end
            if (enq && CW'(i) == wr) begin
                data_d[i]  = in_woken;
                valid_d[i] = 1'b1;
            end
        end
        count_d = count_q;
        if (enq && !issue) count_d = count_q + CW'(1);
        if (!enq && issue) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
        end
    end

endmodule
